// File: rtl/udm_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// udm_bus_arbiter_pkg
//   Shared definitions for the two-master req/ack/resp bus arbiter:
//   FSM state encoding, master IDs and the error word returned when the
//   optional watchdog (UDM_BUS_ARBITER_TIMEOUT_EN) gives up on a read.
// -----------------------------------------------------------------------------
package udm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // no owner
    ARB       = 2'd1,  // registered grant is being applied
    REQ       = 2'd2,  // owner's request is passed to the slave
    WAIT_RESP = 2'd3   // read accepted, waiting for the slave's response
  } state_t;

  localparam logic MID_UDM = 1'b0;
  localparam logic MID_CPU = 1'b1;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/udm_arb_rr.sv
// -----------------------------------------------------------------------------
// udm_arb_rr
//   Two-input round-robin pick. Purely combinational.
//   Ports:
//     req   [1:0] in  request per master (bit 0 = udm, bit 1 = cpu)
//     rr          in  preferred master when both request
//     gnt         out chosen master (meaningful only when valid = 1)
//     valid       out at least one master is requesting
// -----------------------------------------------------------------------------
module udm_arb_rr
  import udm_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = rr;
    // A lone requester wins regardless of the preference.
    if (req == 2'b01) gnt = MID_UDM;
    else if (req == 2'b10) gnt = MID_CPU;
  end

endmodule

// File: rtl/udm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// udm_bus_arbiter
//   Serialises two bus masters (m0 = udm debug master, m1 = cpu data port)
//   onto one slave bus. One transaction in flight; the grant is held until
//   write-ack or read-response and the response is routed back to the owner.
//
//   Handshake: a transfer happens in a cycle where req and ack are both 1.
//   A master holds req and its fields stable until ack. A read completes with
//   a single resp pulse in the ack cycle or any later cycle.
//
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     mN_req_i/we_i/addr_bi/be_bi/wdata_bi   master N request side
//     mN_ack_o/resp_o/rdata_bo     master N ack, read-valid, read data
//     s_req_o/we_o/addr_bo/be_bo/wdata_bo    slave request side
//     s_ack_i/resp_i/rdata_bi      slave ack, read-valid, read data
//     grant_o                      owner (0 = udm, 1 = cpu), valid when busy_o
//     busy_o                       a transaction is owned
//     dbg_state                    current FSM state (debug)
//     timeout_o                    sticky watchdog flag (only with the macro)
//
//   Optional feature: define UDM_BUS_ARBITER_TIMEOUT_EN to add a watchdog that
//   abandons a stalled request or answers a stalled read with ERR_WORD.
// -----------------------------------------------------------------------------
module udm_bus_arbiter
  import udm_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_bi,
  input  logic [DATA_W/8-1:0] m0_be_bi,
  input  logic [DATA_W-1:0]   m0_wdata_bi,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_bo,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_bi,
  input  logic [DATA_W/8-1:0] m1_be_bi,
  input  logic [DATA_W-1:0]   m1_wdata_bi,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_bo,

  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_bo,
  output logic [DATA_W/8-1:0] s_be_bo,
  output logic [DATA_W-1:0]   s_wdata_bo,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_bi,

  output logic                grant_o,
  output logic                busy_o,
`ifdef UDM_BUS_ARBITER_TIMEOUT_EN
  output logic                timeout_o,
`endif
  output logic [1:0]          dbg_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog counter");
  end

  state_t              state;
  logic                rr;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                arb_gnt;
  logic                arb_valid;

  logic                own_req;
  logic                own_we;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W/8-1:0] own_be;
  logic [DATA_W-1:0]   own_wdata;

  logic                in_req;
  logic                xfer;
  logic                resp_fire;
  logic [DATA_W-1:0]   resp_data;
  logic                wait_to;
  logic                req_to;

  udm_arb_rr u_rr (
    .req   ({m1_req_i, m0_req_i}),
    .rr    (rr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Owner's request fields, selected by the registered grant.
  assign own_req   = grant_o ? m1_req_i    : m0_req_i;
  assign own_we    = grant_o ? m1_we_i     : m0_we_i;
  assign own_addr  = grant_o ? m1_addr_bi  : m0_addr_bi;
  assign own_be    = grant_o ? m1_be_bi    : m0_be_bi;
  assign own_wdata = grant_o ? m1_wdata_bi : m0_wdata_bi;

  assign in_req = (state == REQ);
  assign xfer   = in_req & own_req & s_ack_i;

  // Slave side is a combinational pass-through only while in REQ.
  assign s_req_o    = in_req & own_req;
  assign s_we_o     = in_req & own_we;
  assign s_addr_bo  = in_req ? own_addr  : '0;
  assign s_be_bo    = in_req ? own_be    : '0;
  assign s_wdata_bo = in_req ? own_wdata : '0;

`ifdef UDM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        to_hit;

  assign to_hit  = (to_cnt == TO_LAST);
  // A real response or ack in the limit cycle takes precedence.
  assign wait_to = (state == WAIT_RESP) & to_hit & ~s_resp_i;
  assign req_to  = in_req & own_req & ~s_ack_i & to_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      // Cleared on entry to REQ (from ARB) and on entry to WAIT_RESP.
      if (state == ARB || (xfer && !own_we && !s_resp_i)) to_cnt <= '0;
      else if (state == REQ || state == WAIT_RESP) to_cnt <= to_cnt + 16'd1;
      if (wait_to || req_to) timeout_o <= 1'b1;
    end
  end
`else
  assign wait_to = 1'b0;
  assign req_to  = 1'b0;
`endif

  // Read completion: same-cycle ack+resp, late resp, or watchdog answer.
  assign resp_fire = (xfer & ~own_we & s_resp_i)
                   | ((state == WAIT_RESP) & s_resp_i)
                   | wait_to;
  assign resp_data = wait_to ? DATA_W'(ERR_WORD) : s_rdata_bi;

  assign m0_ack_o  = xfer & (grant_o == MID_UDM);
  assign m1_ack_o  = xfer & (grant_o == MID_CPU);
  assign m0_resp_o = resp_fire & (grant_o == MID_UDM);
  assign m1_resp_o = resp_fire & (grant_o == MID_CPU);

  // Read data is held in a register; the response cycle bypasses it so the
  // data is valid together with the resp pulse.
  assign m0_rdata_bo = m0_resp_o ? resp_data : rdata0_q;
  assign m1_rdata_bo = m1_resp_o ? resp_data : rdata1_q;

  assign dbg_state = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr       <= MID_UDM;
      grant_o  <= MID_UDM;
      busy_o   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_resp_o) rdata0_q <= resp_data;
      if (m1_resp_o) rdata1_q <= resp_data;

      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_o <= arb_gnt;
            busy_o  <= 1'b1;
            state   <= ARB;
          end
        end
        ARB: state <= REQ;
        REQ: begin
          if (!own_req) begin
            // Owner withdrew before ack: drop it, preference unchanged.
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (s_ack_i) begin
            if (own_we || s_resp_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              rr     <= ~grant_o;
            end else begin
              state <= WAIT_RESP;
            end
          end else if (req_to) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (s_resp_i || wait_to) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            rr     <= ~grant_o;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_udm_bus_arbiter
//   Directed scenarios with literal expectations, then randomized masters and
//   slave. A transaction-level model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_udm_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we  = '0;
  logic [31:0] m_addr [2];
  logic [3:0]  m_be   [2];
  logic [31:0] m_wd   [2];
  logic        s_ack  = 1'b0;
  logic        s_resp = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        grant_o, busy_o;
  logic [1:0]  dbg_state;
`ifdef UDM_BUS_ARBITER_TIMEOUT_EN
  logic        timeout;
`endif

  udm_bus_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m_req[0]),
    .m0_we_i     (m_we[0]),
    .m0_addr_bi  (m_addr[0]),
    .m0_be_bi    (m_be[0]),
    .m0_wdata_bi (m_wd[0]),
    .m0_ack_o    (m0_ack_o),
    .m0_resp_o   (m0_resp_o),
    .m0_rdata_bo (m0_rdata_bo),
    .m1_req_i    (m_req[1]),
    .m1_we_i     (m_we[1]),
    .m1_addr_bi  (m_addr[1]),
    .m1_be_bi    (m_be[1]),
    .m1_wdata_bi (m_wd[1]),
    .m1_ack_o    (m1_ack_o),
    .m1_resp_o   (m1_resp_o),
    .m1_rdata_bo (m1_rdata_bo),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_bo   (s_addr_bo),
    .s_be_bo     (s_be_bo),
    .s_wdata_bo  (s_wdata_bo),
    .s_ack_i     (s_ack),
    .s_resp_i    (s_resp),
    .s_rdata_bi  (s_rdata),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
`ifdef UDM_BUS_ARBITER_TIMEOUT_EN
    .timeout_o   (timeout),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  logic [0:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy/owner: who holds the bus; age 0 = the cycle the grant settles,
  // age >= 1 = request offered to the slave; acc = read accepted, data owed.
  logic        mb_busy = 1'b0;
  int          mb_owner = 0;
  int          mb_age = 0;
  logic        mb_acc = 1'b0;
  int          mb_rr = 0;
  logic [31:0] mb_last [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin : compare
    int          o;
    logic        in_req, oreq, owe, xfer, rf;
    logic [1:0]  e_ack, e_resp;
    logic [31:0] e_rd0, e_rd1;
    o      = mb_owner;
    in_req = mb_busy && (mb_age >= 1) && !mb_acc;
    oreq   = m_req[o];
    owe    = m_we[o];
    xfer   = in_req && oreq && s_ack;
    rf     = (xfer && !owe && s_resp) || (mb_busy && mb_acc && s_resp);
    e_ack  = xfer ? (2'b01 << o) : 2'b00;
    e_resp = rf   ? (2'b01 << o) : 2'b00;
    e_rd0  = e_resp[0] ? s_rdata : mb_last[0];
    e_rd1  = e_resp[1] ? s_rdata : mb_last[1];

    if (chk_en) begin
      chk("busy",    busy_o, mb_busy);
      if (mb_busy) chk("grant", grant_o, o[0]);
      chk("s_req",   s_req_o,    in_req && oreq);
      chk("s_we",    s_we_o,     in_req && owe);
      chk("s_addr",  s_addr_bo,  in_req ? m_addr[o] : 32'h0);
      chk("s_be",    s_be_bo,    in_req ? m_be[o]   : 4'h0);
      chk("s_wdata", s_wdata_bo, in_req ? m_wd[o]   : 32'h0);
      chk("m0_ack",  m0_ack_o,   e_ack[0]);
      chk("m1_ack",  m1_ack_o,   e_ack[1]);
      chk("m0_resp", m0_resp_o,  e_resp[0]);
      chk("m1_resp", m1_resp_o,  e_resp[1]);
      chk("m0_rdata", m0_rdata_bo, e_rd0);
      chk("m1_rdata", m1_rdata_bo, e_rd1);
    end

    // advance the model across the coming rising edge
    if (rst) begin
      mb_busy = 1'b0; mb_acc = 1'b0; mb_rr = 0; mb_owner = 0;
      mb_last[0] = 32'h0; mb_last[1] = 32'h0;
    end else if (!mb_busy) begin
      if (m_req != 2'b00) begin
        mb_owner = (m_req == 2'b11) ? mb_rr : (m_req[1] ? 1 : 0);
        mb_busy = 1'b1; mb_age = 0; mb_acc = 1'b0;
      end
    end else if (mb_age == 0) begin
      mb_age = 1;
    end else if (!mb_acc) begin
      if (!oreq) mb_busy = 1'b0;
      else if (s_ack) begin
        if (owe) begin
          mb_busy = 1'b0; mb_rr = 1 - o;
        end else if (s_resp) begin
          mb_last[o] = s_rdata; mb_busy = 1'b0; mb_rr = 1 - o;
        end else mb_acc = 1'b1;
      end
    end else if (s_resp) begin
      mb_last[o] = s_rdata; mb_busy = 1'b0; mb_acc = 1'b0; mb_rr = 1 - o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    m_req[m] = req; m_we[m] = we; m_addr[m] = addr; m_be[m] = be; m_wd[m] = wd;
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] wait_r;
  logic [1:0] ack_seen, resp_seen;
  int         n_acks;

  initial begin
    set_m(0, 0, 0, 32'h0, 4'h0, 32'h0);
    set_m(1, 0, 0, 32'h0, 4'h0, 32'h0);
    cyc(); cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy",  busy_o,    1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_sreq",  s_req_o,   1'b0);
    chk("rst_rd0",   m0_rdata_bo, 32'h0);
    cyc(); rst = 1'b0;

    // single udm write, slave acks in the third request cycle
    cyc(); set_m(0, 1, 1, 32'h0, 4'hF, 32'h33CC);
    @(negedge clk); chk("d1_idle_busy", busy_o, 1'b0);
    cyc(); @(negedge clk);
    chk("d1_arb_state", dbg_state, 2'd1); chk("d1_arb_grant", grant_o, 1'b0);
    chk("d1_arb_sreq", s_req_o, 1'b0);
    cyc(); @(negedge clk);
    chk("d1_sreq", s_req_o, 1'b1); chk("d1_swe", s_we_o, 1'b1);
    chk("d1_saddr", s_addr_bo, 32'h0); chk("d1_sbe", s_be_bo, 4'hF);
    chk("d1_swdata", s_wdata_bo, 32'h33CC); chk("d1_noack", m0_ack_o, 1'b0);
    cyc(); @(negedge clk); chk("d1_noack2", m0_ack_o, 1'b0);
    cyc(); s_ack = 1'b1;
    @(negedge clk);
    chk("d1_ack", m0_ack_o, 1'b1); chk("d1_m1_ack", m1_ack_o, 1'b0);
    cyc(); s_ack = 1'b0; m_req[0] = 1'b0;
    @(negedge clk); chk("d1_back_idle", dbg_state, 2'd0); chk("d1_ack_once", m0_ack_o, 1'b0);
    // preference has moved to the cpu
    cyc(); m_req = 2'b11;
    @(negedge clk);
    cyc(); @(negedge clk); chk("d1_rr_flip", grant_o, 1'b1);
    cyc(); rst = 1'b1; m_req = 2'b00;
    @(negedge clk);
    cyc(); rst = 1'b0;
    @(negedge clk); chk("d1_rst_state", dbg_state, 2'd0);

    // concurrent reads, then a zero-latency read for the cpu
    cyc(); set_m(0, 1, 0, 32'h4, 4'hF, 32'h0); set_m(1, 1, 0, 32'h8, 4'hF, 32'h0);
    @(negedge clk);
    cyc(); @(negedge clk); chk("d2_grant_udm", grant_o, 1'b0);
    cyc(); s_ack = 1'b1;
    @(negedge clk);
    chk("d2_saddr0", s_addr_bo, 32'h4); chk("d2_m0_ack", m0_ack_o, 1'b1);
    chk("d2_m1_ack", m1_ack_o, 1'b0);
    cyc(); s_ack = 1'b0; m_req[0] = 1'b0;
    @(negedge clk); chk("d2_wait_state", dbg_state, 2'd3); chk("d2_wait_sreq", s_req_o, 1'b0);
    cyc(); s_resp = 1'b1; s_rdata = 32'h0030;
    @(negedge clk);
    chk("d2_m0_resp", m0_resp_o, 1'b1); chk("d2_m0_rdata", m0_rdata_bo, 32'h30);
    chk("d2_m1_noresp", m1_resp_o, 1'b0);
    cyc(); s_resp = 1'b0; s_rdata = 32'h0;
    @(negedge clk); chk("d2_rd0_hold", m0_rdata_bo, 32'h30);
    cyc(); @(negedge clk); chk("d2_grant_cpu", grant_o, 1'b1);
    cyc(); s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("d3_saddr1", s_addr_bo, 32'h8); chk("d3_m1_resp", m1_resp_o, 1'b1);
    chk("d3_m1_rdata", m1_rdata_bo, 32'hA5A5A5A5); chk("d3_m0_noresp", m0_resp_o, 1'b0);
    cyc(); s_ack = 1'b0; s_resp = 1'b0; m_req[1] = 1'b0;
    set_m(0, 1, 1, 32'hC, 4'h3, 32'h1);
    @(negedge clk); chk("d3_idle", dbg_state, 2'd0);
    cyc(); @(negedge clk); chk("d3_next_arb", busy_o, 1'b1); chk("d3_next_grant", grant_o, 1'b0);
    cyc(); s_ack = 1'b1;
    @(negedge clk); chk("d3_next_ack", m0_ack_o, 1'b1);
    cyc(); s_ack = 1'b0; m_req[0] = 1'b0;

    // reset while waiting for read data; the late response must vanish
    set_m(1, 1, 0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); s_ack = 1'b1;
    @(negedge clk);
    cyc(); s_ack = 1'b0; m_req[1] = 1'b0;
    @(negedge clk); chk("d4_wait_state", dbg_state, 2'd3);
    cyc(); rst = 1'b1;
    @(negedge clk);
    cyc(); rst = 1'b0; s_resp = 1'b1; s_rdata = 32'h1234;
    @(negedge clk);
    chk("d4_m1_noresp", m1_resp_o, 1'b0); chk("d4_m1_rdata0", m1_rdata_bo, 32'h0);
    chk("d4_m0_rdata0", m0_rdata_bo, 32'h0); chk("d4_busy0", busy_o, 1'b0);
    cyc(); s_resp = 1'b0; set_m(1, 1, 1, 32'h20, 4'hF, 32'h77);
    @(negedge clk);
    cyc(); @(negedge clk); chk("d4_regrant", grant_o, 1'b1); chk("d4_regrant_busy", busy_o, 1'b1);
    cyc(); s_ack = 1'b1;
    @(negedge clk); chk("d4_ack", m1_ack_o, 1'b1);
    cyc(); s_ack = 1'b0; m_req[1] = 1'b0;

    // back-to-back fairness: both request continuously, grants alternate
    set_m(0, 1, 1, 32'h40, 4'hF, 32'hA); set_m(1, 1, 1, 32'h80, 4'hF, 32'hB);
    s_ack = 1'b1; n_acks = 0;
    exp_q.push_back(1'b0);
    for (int c = 0; c < 40 && n_acks < 8; c++) begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        if (exp_q.size() > 0) chk("fair_alt", m1_ack_o, exp_q.pop_front());
        exp_q.push_back(~m1_ack_o);
        n_acks++;
      end
      cyc();
    end
    chk("fair_count", n_acks, 8);
    exp_q.delete();
    s_ack = 1'b0; m_req = 2'b00;

    // randomized masters and slave
    wait_r = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ack_seen  = {m1_ack_o, m0_ack_o};
      resp_seen = {m1_resp_o, m0_resp_o};
      cyc();
      rst = ($urandom_range(0, 599) == 0);
      if (rst) begin
        wait_r = 2'b00; m_req = 2'b00;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (wait_r[m]) begin
            if (resp_seen[m]) wait_r[m] = 1'b0;
          end else if (m_req[m]) begin
            if (ack_seen[m]) begin
              m_req[m] = 1'b0;
              wait_r[m] = !m_we[m] && !resp_seen[m];
            end else if ($urandom_range(0, 79) == 0) begin
              m_req[m] = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            set_m(m, 1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
          end
        end
      end
      s_ack   = ($urandom_range(0, 9) < 4);
      s_resp  = ($urandom_range(0, 9) < 4);
      s_rdata = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
